// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: round-robin grant, fixed 3-cycle
// IDLE -> ACCESS -> RESP sequence, read-before-write data return.
module dmem_arbiter #(
  parameter int N = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd,
  output logic        busy
);

  // The full 32-bit address is forwarded; N only documents the downstream width.
  if (N < 1 || N > 32) begin : g_bad_n
  end

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state_reg, state_next;
  logic        cmd_we_reg;
  logic        cmd_id_reg;
  logic [31:0] cmd_addr_reg;
  logic [31:0] cmd_wdata_reg;
  logic        last_reg;
  logic [31:0] rdata_reg [2];
  logic        grant;
  logic        winner;

  always_comb begin
    state_next = state_reg;
    grant      = 1'b0;
    winner     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (m0_req || m1_req) begin
          grant      = 1'b1;
          // Under contention the requester not served last goes first.
          winner     = (m0_req && m1_req) ? ~last_reg : m1_req;
          state_next = ACCESS;
        end
      end
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cmd_we_reg    <= 1'b0;
      cmd_id_reg    <= 1'b0;
      cmd_addr_reg  <= '0;
      cmd_wdata_reg <= '0;
      last_reg      <= 1'b1;
    end else begin
      state_reg <= state_next;
      if (grant) begin
        cmd_we_reg    <= winner ? m1_we    : m0_we;
        cmd_addr_reg  <= winner ? m1_addr  : m0_addr;
        cmd_wdata_reg <= winner ? m1_wdata : m0_wdata;
        cmd_id_reg    <= winner;
        last_reg      <= winner;
      end
    end
  end

  // Each requester owns a read-data register touched only by its own accesses.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rdata
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata_reg[gi] <= '0;
      end else if (state_reg == ACCESS && cmd_id_reg == 1'(gi)) begin
        rdata_reg[gi] <= mem_rd;
      end
    end
  end

  assign busy     = (state_reg != IDLE);
  assign mem_we   = !((state_reg == ACCESS) && cmd_we_reg);
  assign mem_a    = cmd_addr_reg;
  assign mem_wd   = cmd_wdata_reg;
  assign m0_ack   = (state_reg == RESP) && !cmd_id_reg;
  assign m1_ack   = (state_reg == RESP) &&  cmd_id_reg;
  assign m0_rdata = rdata_reg[0];
  assign m1_rdata = rdata_reg[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a word-level memory model predicts the
// response of every access; a monitor compares each ack against the queue.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        m0_req = 1'b0, m1_req = 1'b0;
  logic        m0_we = 1'b0, m1_we = 1'b0;
  logic [31:0] m0_addr = '0, m1_addr = '0;
  logic [31:0] m0_wdata = '0, m1_wdata = '0;
  logic        m0_ack, m1_ack;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;
  logic        busy;

  always #5 clk = ~clk;

  dmem_arbiter #(.N(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .busy(busy)
  );

  // Device memory: combinational read, write on the edge while mem_we is low.
  logic [31:0] sim_mem [16];
  logic        pre_en = 1'b0;
  logic [3:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;
  always @(posedge clk) begin
    if (pre_en) sim_mem[pre_addr] <= pre_data;
    else if (!mem_we) sim_mem[mem_a[3:0]] <= mem_wd;
  end
  assign mem_rd = sim_mem[mem_a[3:0]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        id;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] ref_mem [16];
  logic        ref_last;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, req);
    end
  endtask

  // Reference: an access returns the word held before it and then updates memory.
  task automatic model_access(input logic id, input logic we, input logic [3:0] a, input logic [31:0] wd);
    exp_t e;
    e.id    = id;
    e.rdata = ref_mem[a];
    exp_q.push_back(e);
    if (we) ref_mem[a] = wd;
    ref_last = id;
  endtask

  task automatic drive(input logic id, input logic we, input logic [31:0] a, input logic [31:0] wd);
    if (id) begin
      m1_we = we; m1_addr = a; m1_wdata = wd; m1_req = 1'b1;
    end else begin
      m0_we = we; m0_addr = a; m0_wdata = wd; m0_req = 1'b1;
    end
  endtask

  task automatic preload(input logic [3:0] a, input logic [31:0] v);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = a; pre_data = v;
    ref_mem[a] = v;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic reset_checks();
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b1);
    chk1("rst_m0_ack", m0_ack, 1'b0);
    chk1("rst_m1_ack", m1_ack, 1'b0);
    chk("rst_m0_rdata", m0_rdata, 32'd0);
    chk("rst_m1_rdata", m1_rdata, 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_wd", mem_wd, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
    ref_last = 1'b1;
    #1 reset_checks();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // mode 0: plain; 1: winner inputs changed during ACCESS; 2: other req raised only while busy
  task automatic single(input logic id, input logic we, input logic [31:0] a, input logic [31:0] wd, input int mode);
    logic ack_w, ack_l;
    @(negedge clk);
    drive(id, we, a, wd);
    model_access(id, we, a[3:0], wd);
    @(negedge clk);
    chk1("access_busy", busy, 1'b1);
    chk1("access_mem_we", mem_we, !we);
    chk("access_mem_a", mem_a, a);
    if (we) chk("access_mem_wd", mem_wd, wd);
    if (mode == 1) drive(id, 1'b1, 32'd9, 32'hBAD0_0BAD);
    if (mode == 2) drive(~id, 1'b1, 32'd11, 32'hFEED_F00D);
    @(negedge clk);
    ack_w = id ? m1_ack : m0_ack;
    ack_l = id ? m0_ack : m1_ack;
    chk1("resp_ack_winner", ack_w, 1'b1);
    chk1("resp_ack_other", ack_l, 1'b0);
    chk1("resp_mem_we", mem_we, 1'b1);
    m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clk);
    chk1("idle_busy", busy, 1'b0);
    if (mode == 2) begin
      @(negedge clk);
      chk1("dropped_req_no_grant", busy, 1'b0);
    end
  endtask

  task automatic reset_in_access();
    @(negedge clk);
    drive(1'b0, 1'b1, 32'd3, 32'hAAAA_AAAA);
    @(negedge clk);
    chk1("rip_access_mem_we", mem_we, 1'b0);
    rst_n = 1'b0; m0_req = 1'b0;
    ref_last = 1'b1;
    #1 reset_checks();
    @(negedge clk);
    chk("rip_addr3_unchanged", sim_mem[3], ref_mem[3]);
    chk1("rip_mem_we_held", mem_we, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);
    chk1("rip_idle_after", busy, 1'b0);
  endtask

  task automatic contention();
    int t[4];
    int n;
    int t0;
    n = 0;
    @(negedge clk);
    rst_n = 1'b0;
    ref_last = 1'b1;
    drive(1'b0, 1'b0, 32'd5, 32'd0);
    drive(1'b1, 1'b0, 32'd7, 32'd0);
    for (int i = 0; i < 2; i++) begin
      model_access(~ref_last, 1'b0, (~ref_last) ? 4'd7 : 4'd5, 32'd0);
      model_access(~ref_last, 1'b0, (~ref_last) ? 4'd7 : 4'd5, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    t0 = cyc;
    for (int c = 0; c < 30 && n < 4; c++) begin
      @(negedge clk);
      if (m0_ack || m1_ack) begin
        t[n] = cyc;
        n++;
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    chk("contention_ack_count", 32'(n), 32'd4);
    if (n == 4) begin
      chk("contention_first_latency", 32'(t[0] - t0), 32'd2);
      for (int i = 1; i < 4; i++) chk("contention_ack_spacing", 32'(t[i] - t[i-1]), 32'd3);
    end
    @(negedge clk);
  endtask

  task automatic random_round();
    logic [1:0]  pat;
    logic        r_we [2];
    logic [31:0] r_a  [2];
    logic [31:0] r_wd [2];
    logic        w;
    int          c;
    pat = 2'($urandom_range(1, 3));
    for (int i = 0; i < 2; i++) begin
      r_we[i] = 1'($urandom_range(0, 1));
      r_a[i]  = 32'($urandom_range(0, 15));
      r_wd[i] = $urandom;
    end
    @(negedge clk);
    if (pat[0]) drive(1'b0, r_we[0], r_a[0], r_wd[0]);
    if (pat[1]) drive(1'b1, r_we[1], r_a[1], r_wd[1]);
    if (pat == 2'd3) begin
      w = ~ref_last;
      model_access(w, r_we[w], r_a[w][3:0], r_wd[w]);
      model_access(~w, r_we[~w], r_a[~w][3:0], r_wd[~w]);
    end else begin
      w = pat[1];
      model_access(w, r_we[w], r_a[w][3:0], r_wd[w]);
    end
    c = 0;
    while ((m0_req || m1_req) && c < 12) begin
      @(negedge clk);
      if (m0_ack) m0_req = 1'b0;
      if (m1_ack) m1_req = 1'b0;
      c++;
    end
    checks++;
    if (m0_req || m1_req) begin
      errors++;
      $display("FAIL random_timeout: req still pending after %0d cycles, expected ack within 12", c);
      m0_req = 1'b0; m1_req = 1'b0;
    end
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (m0_ack && m1_ack) begin
          checks++; errors++;
          $display("FAIL dual_ack: m0_ack=1 m1_ack=1, expected at most one");
        end else if (m0_ack || m1_ack) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_ack: m%0d acked, expected no ack", m1_ack);
          end else begin
            mon_e = exp_q.pop_front();
            chk1("ack_id", m1_ack, mon_e.id);
            chk("ack_rdata", m1_ack ? m1_rdata : m0_rdata, mon_e.rdata);
            $display("txn t=%0d m%0d rdata=%h", cyc, m1_ack, m1_ack ? m1_rdata : m0_rdata);
          end
        end
      end
    join_none

    do_reset();
    for (int i = 0; i < 16; i++) preload(4'(i), 32'd0);
    preload(4'd5, 32'hDEAD_BEEF);
    preload(4'd2, 32'h2222_2222);
    preload(4'd9, 32'h9999_9999);
    preload(4'd3, 32'h3333_3333);

    single(1'b0, 1'b0, 32'd5, 32'd0, 0);
    single(1'b1, 1'b1, 32'd7, 32'h1234_5678, 0);
    single(1'b1, 1'b0, 32'd7, 32'd0, 0);
    single(1'b0, 1'b0, 32'd2, 32'd0, 1);
    single(1'b0, 1'b0, 32'd9, 32'd0, 0);
    single(1'b0, 1'b0, 32'd4, 32'd0, 2);
    single(1'b1, 1'b0, 32'd11, 32'd0, 0);

    reset_in_access();
    single(1'b0, 1'b0, 32'd3, 32'd0, 0);

    contention();

    for (int r = 0; r < 40; r++) random_round();

    repeat (4) @(negedge clk);
    chk("pending_responses", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
